rs232_tx: RTL and testbench

RS232_TX -- requirements
Module: rs232_tx

---
 rtl/rs232_pkg.sv | 21 ++
 rtl/clk_div_tx.sv | 28 ++
 rtl/rs232_tx.sv | 138 +++++++++++++
 tb/tb_rs232_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS-232 transmitter definitions: FSM state encoding and frame constants.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam logic        IDLE_LEVEL  = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/clk_div_tx.sv
// Bit-period divider: while enabled, pulses z_o for one cycle every baud_i+1 clocks.
module clk_div_tx #(
    parameter int unsigned Width = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] baud_i,
    output logic             z_o
);

    logic [Width-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (!en_i || cnt == baud_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        z_o = en_i && (cnt == baud_i);
    end

endmodule

// File: rtl/rs232_tx.sv
// RS-232 frame transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define RS232_TX_TWO_STOP_EN to send two stop bits instead of one.
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int unsigned Width = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] baud_i,
    input  logic             psel_i,
    input  logic [7:0]       din_i,
    input  logic             start_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             eot_o
);

    tx_state_t        state;
    logic [7:0]       shreg;
    logic [3:0]       bit_cnt;
    logic             psel_q;
    logic             par_q;
    logic [Width-1:0] baud_q;
    logic             div_en;
    logic             tick;
`ifdef RS232_TX_TWO_STOP_EN
    logic             stop2;
`endif

    always_comb begin
        div_en = (state != IDLE);
    end

    clk_div_tx #(
        .Width (Width)
    ) u_clk_div_tx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (div_en),
        .baud_i (baud_q),
        .z_o    (tick)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            tx_o    <= IDLE_LEVEL;
            busy_o  <= 1'b0;
            eot_o   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            psel_q  <= 1'b0;
            par_q   <= 1'b0;
            baud_q  <= '0;
`ifdef RS232_TX_TWO_STOP_EN
            stop2   <= 1'b0;
`endif
        end else begin
            eot_o <= 1'b0;
            case (state)
                IDLE: begin
                    tx_o <= IDLE_LEVEL;
                    if (start_i) begin
                        shreg  <= din_i;
                        par_q  <= even_parity(din_i);
                        psel_q <= psel_i;
                        baud_q <= baud_i;
                        tx_o   <= START_LEVEL;
                        busy_o <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_o    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            if (psel_q) begin
                                tx_o  <= par_q;
                                state <= PARITY;
                            end else begin
                                tx_o  <= STOP_LEVEL;
                                state <= STOP;
`ifdef RS232_TX_TWO_STOP_EN
                                stop2 <= 1'b0;
`endif
                            end
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_o  <= STOP_LEVEL;
                        state <= STOP;
`ifdef RS232_TX_TWO_STOP_EN
                        stop2 <= 1'b0;
`endif
                    end
                end
                STOP: begin
                    if (tick) begin
`ifdef RS232_TX_TWO_STOP_EN
                        // First stop period only arms the second one.
                        if (!stop2) begin
                            stop2 <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            eot_o  <= 1'b1;
                        end
`else
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        eot_o  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_o   <= IDLE_LEVEL;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// Self-checking bench for rs232_tx: frame-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_rs232_tx;

`ifdef RS232_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
    localparam int EOT_B0 = 12;
`else
    localparam int NSTOP = 1;
    localparam int EOT_B0 = 11;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [14:0] baud_i = '0;
    logic        psel_i = 1'b0;
    logic [7:0]  din_i = '0;
    logic        start_i = 1'b0;
    logic        tx_o, busy_o, eot_o;

    int n_tests = 0;
    int n_fail  = 0;

    rs232_tx #(.Width(15)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .baud_i  (baud_i),
        .psel_i  (psel_i),
        .din_i   (din_i),
        .start_i (start_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .eot_o   (eot_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: the list of line levels, one entry per bit period.
    function automatic void build(input logic [7:0] d, input logic p, output logic [11:0] f, output int n);
        f = '0;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
        if (p) begin f[n] = ^d; n++; end
        for (int s = 0; s < NSTOP; s++) begin f[n] = 1'b1; n++; end
    endfunction

    int          edge_n = 0;
    int          acc    = 0;
    bit          active = 0;
    logic [11:0] m_frame;
    int          m_nbits;
    int          m_b;

    always @(posedge clk_i) begin
        int  len;
        bit  m_busy;
        len    = m_nbits * (m_b + 1);
        m_busy = active && (edge_n - acc) < len;
        if (rst_i && !m_busy && start_i) begin
            build(din_i, psel_i, m_frame, m_nbits);
            m_b    = int'(baud_i);
            acc    = edge_n + 1;
            active = 1;
        end
        edge_n = edge_n + 1;
    end

    always @(negedge rst_i) active = 0;

    always @(negedge clk_i) begin
        int d, len;
        logic etx, ebusy, eeot;
        etx = 1'b1; ebusy = 1'b0; eeot = 1'b0;
        if (active) begin
            d   = edge_n - acc;
            len = m_nbits * (m_b + 1);
            if (d < len) begin
                etx   = m_frame[d / (m_b + 1)];
                ebusy = 1'b1;
            end else if (d == len) begin
                eeot = 1'b1;
            end
        end
        check("model_tx", 32'(tx_o), 32'(etx));
        check("model_busy", 32'(busy_o), 32'(ebusy));
        check("model_eot", 32'(eot_o), 32'(eeot));
    end

    // Drive a request; returns at the falling edge of the first cycle after acceptance.
    task automatic accept(input logic [7:0] d, input logic p, input int b, input bit hold);
        @(negedge clk_i);
        din_i   = d;
        psel_i  = p;
        baud_i  = 15'(b);
        start_i = 1'b1;
        @(negedge clk_i);
        if (!hold) start_i = 1'b0;
    endtask

    task automatic sample_frame(input int b, input int nbits, input int poke_cyc, input logic [7:0] poke_din,
                                output logic [11:0] got, output int eot_cyc,
                                output logic after_tx, output logic after_busy);
        got = '0; eot_cyc = 0; after_tx = 1'bx; after_busy = 1'bx;
        for (int k = 1; k <= nbits * (b + 1) + 5; k++) begin
            if (k > 1) @(negedge clk_i);
            if ((k - 1) % (b + 1) == b / 2 && (k - 1) / (b + 1) < nbits)
                got[(k - 1) / (b + 1)] = tx_o;
            if (eot_o && eot_cyc == 0) eot_cyc = k;
            if (eot_cyc != 0 && k == eot_cyc + 1) begin
                after_tx = tx_o; after_busy = busy_o;
            end
            if (poke_cyc != 0 && k == poke_cyc) begin
                start_i = 1'b1; din_i = poke_din;
            end
            if (poke_cyc != 0 && k == poke_cyc + 1) start_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o !== 1'b0 || eot_o !== 1'b0) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) check("wait_idle_timeout", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        logic [11:0] got;
        int          ec;
        logic        atx, abusy;
        int          eot_cnt;

        repeat (3) @(negedge clk_i);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_eot", 32'(eot_o), 32'd0);
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // A5, no parity, 5 cycles/bit
        accept(8'hA5, 1'b0, 4, 0);
        sample_frame(4, 10, 0, 8'h00, got, ec, atx, abusy);
        check("a5_bits", 32'(got[9:0]), 32'(10'b1101001010));
        check("a5_eot_cycle", 32'(ec), 32'd51);
        wait_idle();

        // 07 with parity
        accept(8'h07, 1'b1, 4, 0);
        sample_frame(4, 11, 0, 8'h00, got, ec, atx, abusy);
        check("p07_bits", 32'(got[10:0]), 32'(11'b11000001110));
        check("p07_parity", 32'(got[9]), 32'd1);
        check("p07_eot_cycle", 32'(ec), 32'd56);
        wait_idle();

        // A5 with parity
        accept(8'hA5, 1'b1, 4, 0);
        sample_frame(4, 11, 0, 8'h00, got, ec, atx, abusy);
        check("pa5_parity", 32'(got[9]), 32'd0);
        check("pa5_stop", 32'(got[10]), 32'd1);
        check("pa5_eot_cycle", 32'(ec), 32'd56);
        wait_idle();

        // start held high: back-to-back frames
        accept(8'h3C, 1'b0, 1, 1);
        sample_frame(1, 10, 0, 8'h00, got, ec, atx, abusy);
        check("b2b_bits", 32'(got[9:0]), 32'(10'b1001111000));
        check("b2b_eot_cycle", 32'(ec), 32'd21);
        check("b2b_next_start_tx", 32'(atx), 32'd0);
        check("b2b_next_busy", 32'(abusy), 32'd1);
        repeat (30) @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();

        // mid-frame request with new data must be ignored
        accept(8'h5A, 1'b0, 2, 0);
        sample_frame(2, 10, 10, 8'hFF, got, ec, atx, abusy);
        check("ign_bits", 32'(got[9:0]), 32'(10'b1010110100));
        check("ign_eot_cycle", 32'(ec), 32'd31);
        check("ign_no_restart", 32'(abusy), 32'd0);
        wait_idle();

        // reset during DATA
        accept(8'hA5, 1'b0, 4, 0);
        repeat (20) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("rst_tx_async", 32'(tx_o), 32'd1);
        check("rst_busy_async", 32'(busy_o), 32'd0);
        check("rst_eot_async", 32'(eot_o), 32'd0);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        eot_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (eot_o) eot_cnt++;
        end
        check("rst_no_eot", 32'(eot_cnt), 32'd0);

        // baud 0: one cycle per bit
        accept(8'h96, 1'b0, 0, 0);
        sample_frame(0, 9 + NSTOP, 0, 8'h00, got, ec, atx, abusy);
        check("b0_data", 32'(got[8:1]), 32'h96);
        check("b0_stop", 32'(got[9 + NSTOP - 1]), 32'd1);
        check("b0_eot_cycle", 32'(ec), 32'(EOT_B0));
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
